// File: rtl/feature_matcher.sv
// Descriptor matcher: latches a 6x6 candidate patch, reads one DB word and
// accumulates the SAD over LANES bytes per cycle, then reports sad <= threshold.
module feature_matcher #(
    parameter int unsigned LANES = 4,
    parameter int unsigned SADW  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              patchValid,
    output logic              patchReady,
    input  logic [287:0]      patch,
    input  logic [SADW-1:0]   threshold,
    output logic              matReaden,
    input  logic [287:0]      dbValue,
    output logic              matchValid,
    input  logic              matchReady,
    output logic              isMatch,
    output logic [SADW-1:0]   sad
);

    localparam int unsigned NBYTES = 36;
    localparam int unsigned PW     = NBYTES * 8;
    localparam int unsigned GW     = LANES * 8;
    localparam int unsigned GROUPS = NBYTES / LANES;
    localparam int unsigned IDXW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned LSW    = 8 + $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_patch;
    logic [PW-1:0]     r_db;
    logic [SADW-1:0]   r_thr;
    logic [SADW-1:0]   r_acc;
    logic [IDXW-1:0]   r_idx;
    logic              r_patch_ready;
    logic              r_mat_readen;
    logic              r_match_valid;
    logic              r_is_match;
    logic [SADW-1:0]   r_sad;

    logic [LSW-1:0]    w_lane_sum;
    logic [SADW-1:0]   w_acc_next;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = (a >= b) ? (9'(a) - 9'(b)) : (9'(b) - 9'(a));
        return d[7:0];
    endfunction

    // Lane sum over the current group, which always sits in the top GW bits
    // because the working copies are shifted left after each group.
    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            w_lane_sum = w_lane_sum + LSW'(abs_diff(r_patch[PW-1-8*l -: 8],
                                                    r_db[PW-1-8*l -: 8]));
        end
        w_acc_next = r_acc + SADW'(w_lane_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_patch       <= '0;
            r_db          <= '0;
            r_thr         <= '0;
            r_acc         <= '0;
            r_idx         <= '0;
            r_patch_ready <= 1'b0;
            r_mat_readen  <= 1'b0;
            r_match_valid <= 1'b0;
            r_is_match    <= 1'b0;
            r_sad         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_patch_ready <= 1'b1;
                    if (patchValid && r_patch_ready) begin
                        r_patch       <= patch;
                        r_thr         <= threshold;
                        r_patch_ready <= 1'b0;
                        r_mat_readen  <= 1'b1;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_db         <= dbValue;
                    r_mat_readen <= 1'b0;
                    r_acc        <= '0;
                    r_idx        <= '0;
                    r_state      <= S_ACCUM;
                end
                S_ACCUM: begin
                    r_acc   <= w_acc_next;
                    r_patch <= r_patch << GW;
                    r_db    <= r_db << GW;
                    r_idx   <= r_idx + IDXW'(1);
                    if (r_idx == IDXW'(GROUPS - 1)) begin
                        r_sad         <= w_acc_next;
                        r_is_match    <= (w_acc_next <= r_thr);
                        r_match_valid <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (matchReady) begin
                        r_match_valid <= 1'b0;
                        r_patch_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign patchReady = r_patch_ready;
    assign matReaden  = r_mat_readen;
    assign matchValid = r_match_valid;
    assign isMatch    = r_is_match;
    assign sad        = r_sad;

endmodule

// File: tb/tb_feature_matcher.sv
// Directed bench for feature_matcher: hand-computed SADs against a fixed DB word,
// latency, read-enable width, backpressure and mid-operation reset.
module tb_feature_matcher;

    localparam int unsigned SADW = 14;

    logic              clk;
    logic              rst_n;
    logic              patchValid;
    logic              patchReady;
    logic [287:0]      patch;
    logic [SADW-1:0]   threshold;
    logic              matReaden;
    logic [287:0]      dbValue;
    logic              matchValid;
    logic              matchReady;
    logic              isMatch;
    logic [SADW-1:0]   sad;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [287:0] DB_PAT = {
        {4{8'd95}}, {4{8'd0}}, {4{8'd95}},
        8'd159, 8'd159, 8'd255, 8'd255, {4{8'd159}}, 8'd255, 8'd255, 8'd159, 8'd159,
        {4{8'd95}}, {4{8'd0}}, {4{8'd95}}
    };
    localparam logic [287:0] JUNK = {36{8'h5A}};

    // DB word only valid during the read cycle; junk otherwise
    assign dbValue = matReaden ? DB_PAT : JUNK;

    feature_matcher #(.LANES(4), .SADW(SADW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .patchValid (patchValid),
        .patchReady (patchReady),
        .patch      (patch),
        .threshold  (threshold),
        .matReaden  (matReaden),
        .dbValue    (dbValue),
        .matchValid (matchValid),
        .matchReady (matchReady),
        .isMatch    (isMatch),
        .sad        (sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present a patch and return #1 after the accepting edge (LOAD cycle).
    task automatic start(input logic [287:0] p, input logic [SADW-1:0] thr);
        int waited;
        patch      = p;
        threshold  = thr;
        patchValid = 1'b1;
        waited     = 0;
        while (!patchReady && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("accept_wait", 32'(waited < 50), 32'd1);
        @(posedge clk); #1;
        patchValid = 1'b0;
        threshold  = '0;
        patch      = '1;
    endtask

    task automatic wait_result(input int exp_sad, input logic exp_m, input int bp);
        int cyc;
        int rd;
        cyc = 1;
        rd  = 0;
        while (!matchValid && cyc < 40) begin
            if (matReaden) rd++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'd11);
        chk("readen_cycles", 32'(rd), 32'd1);
        chk("sad", 32'(sad), 32'(exp_sad));
        chk("is_match", 32'(isMatch), 32'(exp_m));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(matchValid), 32'd1);
            chk("bp_sad", 32'(sad), 32'(exp_sad));
            chk("bp_match", 32'(isMatch), 32'(exp_m));
            chk("bp_ready", 32'(patchReady), 32'd0);
        end
        matchReady = 1'b1;
        @(posedge clk); #1;
        matchReady = 1'b0;
        chk("valid_drop", 32'(matchValid), 32'd0);
        chk("ready_back", 32'(patchReady), 32'd1);
        chk("sad_hold", 32'(sad), 32'(exp_sad));
    endtask

    initial begin
        rst_n      = 1'b1;
        patchValid = 1'b0;
        patch      = '0;
        threshold  = '0;
        matchReady = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(patchReady), 32'd0);
        chk("rst_readen", 32'(matReaden), 32'd0);
        chk("rst_valid", 32'(matchValid), 32'd0);
        chk("rst_sad", 32'(sad), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(patchReady), 32'd1);

        // Exact match, with the next patch held pending under backpressure
        start(DB_PAT, 14'd0);
        patch      = '0;
        threshold  = 14'd3812;
        patchValid = 1'b1;
        wait_result(0, 1'b1, 5);
        start('0, 14'd3812);
        wait_result(3812, 1'b1, 0);

        start('0, 14'd3811);
        wait_result(3812, 1'b0, 0);

        start('1, 14'd9180);
        wait_result(5368, 1'b1, 0);

        start({36{8'd95}}, 14'd1000);
        wait_result(1912, 1'b0, 0);

        start('1, 14'd9180);
        wait_result(5368, 1'b1, 0);

        // Abort during ACCUM
        start('1, 14'd9180);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(matchValid), 32'd0);
        chk("abort_sad", 32'(sad), 32'd0);
        chk("abort_match", 32'(isMatch), 32'd0);
        chk("abort_readen", 32'(matReaden), 32'd0);
        chk("abort_ready", 32'(patchReady), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", 32'(patchReady), 32'd1);
        chk("abort_noresult", 32'(matchValid), 32'd0);
        start('0, 14'd3812);
        wait_result(3812, 1'b1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/feature_matcher.md
Name: feature_matcher

Overview:
- Consumer of the feature-descriptor DB memory (36 x 8-bit mean values, 288-bit word, valid while matReaden=1).
- Accepts a 6x6 candidate patch from the FAST9 corner stage, reads the DB word, computes sum of absolute differences (SAD) over LANES bytes per cycle, and reports match if SAD <= threshold.
- Results leave on a valid/ready handshake to the keypoint output stage.

Parameters:
- LANES, 4, bytes compared per accumulate cycle; must divide 36 (1,2,3,4,6,9,12,18,36).
- SADW, 14, SAD width (36*255=9180 fits 14 bits).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- patchValid  input  1  candidate patch present
- patchReady  output  1  block can accept patch
- patch  input  288  36 pixels, byte 0 = bits[287:280], byte 35 = bits[7:0], row-major 6x6
- threshold  input  SADW  match threshold, sampled at accept
- matReaden  output  1  read enable to DB memory
- dbValue  input  288  DB descriptor, same byte order as patch; valid only while matReaden=1
- matchValid  output  1  result valid
- matchReady  input  1  downstream accepts result
- isMatch  output  1  1 when sad <= threshold
- sad  output  SADW  computed SAD

Behaviour:
- Reset (async, rst_n=0): state IDLE; patchReady=0 during reset, 1 in IDLE after release; matReaden=0, matchValid=0, isMatch=0, sad=0, accumulator and index cleared.
- States: IDLE, LOAD, ACCUM, DONE.
- IDLE: patchReady=1. On patchValid&&patchReady, latch patch and threshold, go LOAD. Patch is not re-sampled until the next IDLE.
- LOAD (1 cycle): matReaden=1; register dbValue at the clock edge; clear accumulator; index=0; go ACCUM. matReaden is 0 in every other state.
- ACCUM (36/LANES cycles): each cycle add sum over lanes of |patch[b]-db[b]| for bytes b=index*LANES..index*LANES+LANES-1.
  - Abs diff is computed unsigned 9-bit, then truncated to 8 bits.
  - Lane sum width: 8+ceil(log2(LANES)) bits. Accumulate into SADW bits; no overflow is possible.
  - After the last group, go DONE.
- DONE: matchValid=1. sad holds the final SAD. isMatch=(sad<=threshold), unsigned compare, registered on DONE entry.
  - Outputs hold stable while matchReady=0.
  - On matchValid&&matchReady, go IDLE; matchValid drops the next cycle.
  - sad and isMatch hold their last values until the next DONE.
- Latency (LANES=4): accept edge at cycle 0, LOAD cycle 1, ACCUM cycles 2-10, matchValid high from cycle 11. Total 36/LANES+2 cycles from accept to valid.
- Throughput: one patch per 36/LANES+3 cycles. No overlap; patchReady=0 outside IDLE.
- patchValid held high while busy: ignored; the patch is taken on the next IDLE cycle.
- Reset asserted mid-operation: immediate return to reset values; the in-flight patch is discarded and no result is produced.
- threshold changes after accept have no effect.

Test Plan:
- Patch = DB pattern (rows 95,95,95,95,0,0,0,0,95,95,95,95 / 159,159,255,255,159,159,159,159,255,255,159,159 / repeat first row) with threshold=0 -> sad=0, isMatch=1, matchValid at cycle 11 after accept.
- Patch all 0x00, threshold=3812 -> sad=3812, isMatch=1. Same patch with threshold=3811 -> isMatch=0.
- Patch all 0xFF, threshold=9180 -> sad=5368, isMatch=1.
- Check matReaden: high exactly 1 cycle per patch. dbValue forced to X outside that cycle must not corrupt sad.
- Backpressure: matchReady=0 for 5 cycles in DONE -> matchValid, sad, isMatch stable and patchReady=0. With patchValid held high, the next patch is accepted only after the handshake.
- rst_n pulsed low during ACCUM -> all outputs 0 asynchronously; after release patchReady=1. A new all-zero patch yields sad=3812 with no residue from the aborted patch.
